// File: rtl/result_serializer.sv
// Parallel-to-serial result drain: accepts W-bit words over valid/ready and
// shifts them out MSB-first with first/last strobes, back-to-back capable.
module result_serializer #(
    parameter int unsigned W          = 32,
    parameter int unsigned BIT_CYCLES = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         ser_out,
    output logic         ser_valid,
    output logic         ser_first,
    output logic         ser_last,
    output logic         busy
);

    localparam int unsigned BW = $clog2(W);
    localparam int unsigned CW = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;

    localparam logic [BW-1:0] BIT_TOP  = BW'(W - 1);
    localparam logic [CW-1:0] CYC_LAST = CW'(BIT_CYCLES - 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state, state_nxt;
    logic [W-1:0]  shift_reg, shift_nxt;
    logic [BW-1:0] bit_cnt, bit_nxt;
    logic [CW-1:0] cyc_cnt, cyc_nxt;
    logic          ready_raw;
    logic          out_nxt, valid_nxt, first_nxt, last_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shift_reg <= '0;
            bit_cnt   <= '0;
            cyc_cnt   <= '0;
            ser_out   <= 1'b0;
            ser_valid <= 1'b0;
            ser_first <= 1'b0;
            ser_last  <= 1'b0;
        end else begin
            state     <= state_nxt;
            shift_reg <= shift_nxt;
            bit_cnt   <= bit_nxt;
            cyc_cnt   <= cyc_nxt;
            ser_out   <= out_nxt;
            ser_valid <= valid_nxt;
            ser_first <= first_nxt;
            ser_last  <= last_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        shift_nxt = shift_reg;
        bit_nxt   = bit_cnt;
        cyc_nxt   = cyc_cnt;
        ready_raw = 1'b0;

        case (state)
            IDLE: begin
                ready_raw = 1'b1;
                if (in_valid && !rst) begin
                    shift_nxt = in_data;
                    bit_nxt   = BIT_TOP;
                    cyc_nxt   = '0;
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cyc_cnt == CYC_LAST) begin
                    if (bit_cnt == '0) begin
                        // Final bit cycle: a new word reloads without an idle gap
                        ready_raw = 1'b1;
                        if (in_valid && !rst) begin
                            shift_nxt = in_data;
                            bit_nxt   = BIT_TOP;
                            cyc_nxt   = '0;
                        end else begin
                            shift_nxt = '0;
                            cyc_nxt   = '0;
                            state_nxt = IDLE;
                        end
                    end else begin
                        shift_nxt = {shift_reg[W-2:0], 1'b0};
                        bit_nxt   = bit_cnt - BW'(1);
                        cyc_nxt   = '0;
                    end
                end else begin
                    cyc_nxt = cyc_cnt + CW'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase

        valid_nxt = (state_nxt == SHIFT);
        out_nxt   = valid_nxt & shift_nxt[W-1];
        first_nxt = valid_nxt && (bit_nxt == BIT_TOP);
        last_nxt  = valid_nxt && (bit_nxt == '0);
    end

    assign in_ready = ready_raw & ~rst;
    assign busy     = ser_valid;

endmodule

// File: tb/tb_result_serializer.sv
// Directed bench for result_serializer: W=8 instances with BIT_CYCLES of 1 and 3.
module tb_result_serializer;

    logic       clk;
    logic       rst;
    logic       in_valid, in_valid_b;
    logic [7:0] in_data, in_data_b;
    logic       in_ready, ser_out, ser_valid, ser_first, ser_last, busy;
    logic       in_ready_b, ser_out_b, ser_valid_b, ser_first_b, ser_last_b, busy_b;

    int unsigned checks;
    int unsigned errors;

    result_serializer #(.W(8), .BIT_CYCLES(1)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .in_ready (in_ready),
        .ser_out  (ser_out),
        .ser_valid(ser_valid),
        .ser_first(ser_first),
        .ser_last (ser_last),
        .busy     (busy)
    );

    result_serializer #(.W(8), .BIT_CYCLES(3)) dut_b (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid_b),
        .in_data  (in_data_b),
        .in_ready (in_ready_b),
        .ser_out  (ser_out_b),
        .ser_valid(ser_valid_b),
        .ser_first(ser_first_b),
        .ser_last (ser_last_b),
        .busy     (busy_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0] data;
        logic [7:0] bits;   // expected ser_out sequence, first bit in [7]
    } vec_t;

    vec_t vecs[6];

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    // Accept a word on dut from IDLE; returns #1 after the accept edge.
    task automatic send_a(input logic [7:0] data);
        @(negedge clk);
        check1("idle_ready", in_ready, 1'b1);
        in_valid = 1'b1;
        in_data  = data;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = ~data;
    endtask

    // Check the 8 frame cycles following an accept, then the idle cycle.
    task automatic frame_a(input logic [7:0] bits);
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk);
            check1("frame_valid", ser_valid, 1'b1);
            check1("frame_busy", busy, 1'b1);
            check1("frame_out", ser_out, bits[7-i]);
            check1("frame_first", ser_first, i == 0);
            check1("frame_last", ser_last, i == 7);
            check1("frame_ready", in_ready, i == 7);
        end
        @(negedge clk);
        check1("post_valid", ser_valid, 1'b0);
        check1("post_out", ser_out, 1'b0);
        check1("post_ready", in_ready, 1'b1);
    endtask

    task automatic check_all_zero(input string name);
        check1({name, "_ready"}, in_ready, 1'b0);
        check1({name, "_out"}, ser_out, 1'b0);
        check1({name, "_valid"}, ser_valid, 1'b0);
        check1({name, "_first"}, ser_first, 1'b0);
        check1({name, "_last"}, ser_last, 1'b0);
        check1({name, "_busy"}, busy, 1'b0);
    endtask

    logic [7:0] bp_data[8];

    initial begin
        checks     = 0;
        errors     = 0;
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_data    = '0;
        in_valid_b = 1'b0;
        in_data_b  = '0;

        vecs[0] = '{data: 8'hA5, bits: 8'b1010_0101};
        vecs[1] = '{data: 8'h00, bits: 8'b0000_0000};
        vecs[2] = '{data: 8'hFF, bits: 8'b1111_1111};
        vecs[3] = '{data: 8'h01, bits: 8'b0000_0001};
        vecs[4] = '{data: 8'h80, bits: 8'b1000_0000};
        vecs[5] = '{data: 8'h6C, bits: 8'b0110_1100};

        bp_data[2] = 8'h3C; bp_data[3] = 8'h5A; bp_data[4] = 8'hA5;
        bp_data[5] = 8'h12; bp_data[6] = 8'h34; bp_data[7] = 8'h3C;

        // Reset state
        @(negedge clk);
        check_all_zero("reset");
        check1("reset_b_ready", in_ready_b, 1'b0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check1("release_ready", in_ready, 1'b1);
        check1("release_valid", ser_valid, 1'b0);

        // Table-driven single frames
        for (int unsigned v = 0; v < 6; v++) begin
            send_a(vecs[v].data);
            frame_a(vecs[v].bits);
        end

        // Reset asserted with in_valid high while idle
        @(posedge clk);
        #1;
        in_valid = 1'b1;
        in_data  = 8'hC3;
        rst      = 1'b1;
        @(negedge clk);
        check_all_zero("rst_idle");
        @(negedge clk);
        check_all_zero("rst_hold");
        @(posedge clk);
        #1;
        rst      = 1'b0;
        in_valid = 1'b0;
        @(negedge clk);
        check1("rst_rel_ready", in_ready, 1'b1);
        check1("rst_rel_valid", ser_valid, 1'b0);

        // Back-to-back FF then 00 with in_valid held
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 8'hFF;
        @(posedge clk);
        #1 in_data = 8'h00;
        for (int unsigned i = 0; i < 16; i++) begin
            @(negedge clk);
            check1("b2b_valid", ser_valid, 1'b1);
            check1("b2b_out", ser_out, i < 8);
            check1("b2b_ready", in_ready, (i == 7) || (i == 15));
            check1("b2b_first", ser_first, (i == 0) || (i == 8));
            check1("b2b_last", ser_last, (i == 7) || (i == 15));
            if (i == 15) in_valid = 1'b0;
        end
        @(negedge clk);
        check1("b2b_end_valid", ser_valid, 1'b0);

        // Backpressure: word offered mid-frame, data churning until accepted
        send_a(8'h96);
        for (int unsigned i = 0; i < 8; i++) begin
            @(negedge clk);
            check1("bp_out", ser_out, vecs[5].bits[7-i] ^ (8'h96 >> (7 - i)) ^ vecs[5].bits[7-i]);
            check1("bp_first", ser_first, i == 0);
            check1("bp_last", ser_last, i == 7);
            check1("bp_ready", in_ready, i == 7);
            if (i >= 2) begin
                in_valid = 1'b1;
                in_data  = bp_data[i];
            end
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = 8'hFF;
        frame_a(8'b0011_1100);

        // Reset mid-frame after 4 bits of F0, then a clean 0F frame
        send_a(8'hF0);
        for (int unsigned i = 0; i < 4; i++) begin
            @(negedge clk);
            check1("abort_pre_out", ser_out, i < 4);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        check_all_zero("abort");
        @(posedge clk);
        #1 rst = 1'b0;
        for (int unsigned i = 0; i < 3; i++) begin
            @(negedge clk);
            check1("abort_idle_valid", ser_valid, 1'b0);
            check1("abort_idle_ready", in_ready, 1'b1);
        end
        send_a(8'h0F);
        frame_a(8'b0000_1111);

        // Bit stretch on the BIT_CYCLES=3 instance
        @(negedge clk);
        check1("b_idle_ready", in_ready_b, 1'b1);
        in_valid_b = 1'b1;
        in_data_b  = 8'h81;
        @(posedge clk);
        #1;
        in_valid_b = 1'b0;
        in_data_b  = 8'h7E;
        for (int unsigned c = 0; c < 24; c++) begin
            @(negedge clk);
            check1("b_valid", ser_valid_b, 1'b1);
            check1("b_busy", busy_b, 1'b1);
            check1("b_out", ser_out_b, (c < 3) || (c >= 21));
            check1("b_first", ser_first_b, c < 3);
            check1("b_last", ser_last_b, c >= 21);
            check1("b_ready", in_ready_b, c == 23);
        end
        @(negedge clk);
        check1("b_end_valid", ser_valid_b, 1'b0);
        check1("b_end_ready", in_ready_b, 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/result_serializer.md
# result_serializer

Drains W-bit result words from the parallel ALU output registers and shifts them out MSB-first on a one-wire serial stream with framing strobes. Sits downstream of the ALU result register stage: it accepts a word through a valid/ready handshake, then owns the serial link until the last bit has been sent. It supports back-to-back words with no idle gap, so a continuous stream of results serializes at full link rate.

## Interface
- W, 32: word width in bits; legal range W >= 2.
- BIT_CYCLES, 1: clock cycles each bit is held on ser_out; legal range BIT_CYCLES >= 1.

- clk  input  1  rising-edge clock for all state.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a word to send.
- in_data  input  W  result word. Sampled only on the accept edge.
- in_ready  output  1  block can accept a word this cycle. Combinational from state and counters.
- ser_out  output  1  serial data, MSB first. Registered.
- ser_valid  output  1  ser_out carries a frame bit. Registered.
- ser_first  output  1  current bit is bit W-1, the first bit of the frame. Registered.
- ser_last  output  1  current bit is bit 0, the last bit of the frame. Registered.
- busy  output  1  a frame is in progress. Equal to ser_valid.

## Operation
- Accept rule: a word is accepted on a rising edge where in_valid && in_ready. Changes to in_data after that edge have no effect on the frame.
- State IDLE:
  - in_ready = 1.
  - All serial outputs are 0.
  - On accept: load shift_reg <= in_data, set bit_cnt = W-1 and cyc_cnt = 0, and go to SHIFT.
- State SHIFT:
  - ser_valid = 1 and ser_out = shift_reg[W-1].
  - cyc_cnt counts 0..BIT_CYCLES-1.
  - On the edge where cyc_cnt == BIT_CYCLES-1: shift shift_reg left by 1, decrement bit_cnt, and clear cyc_cnt.
- Final bit cycle: the cycle with bit_cnt == 0 and cyc_cnt == BIT_CYCLES-1.
  - in_ready = 1 during this cycle; it is 0 during every other SHIFT cycle.
  - If a word is accepted on this edge, reload and stay in SHIFT. The new frame's first bit appears the very next cycle.
  - Otherwise go to IDLE and drive the serial outputs to 0.
- Flags:
  - ser_first = 1 while bit_cnt == W-1.
  - ser_last = 1 while bit_cnt == 0.
  - Each flag is held for all BIT_CYCLES cycles of its bit.
- Counter widths: bit_cnt is $clog2(W) bits; cyc_cnt is max(1, $clog2(BIT_CYCLES)) bits. Neither counter wraps past its terminal value.
- Reset:
  - While rst is high, the state is forced to IDLE, all registered outputs are 0, and in_ready is forced to 0.
  - rst asserted mid-frame aborts the frame immediately. The partial word is discarded and not resumed.
  - in_ready = 1 from the first cycle after rst deasserts.
- in_valid in any cycle where in_ready = 0 is ignored. The upstream stage must hold the word; the block does not latch it.

## Timing
- Latency: if a word is accepted at edge N, bit W-1 appears on ser_out in the cycle following edge N.
- Frame length: W*BIT_CYCLES cycles. ser_valid stays high continuously for the whole frame.
- Throughput: one word per W*BIT_CYCLES cycles when in_valid is held high. No idle cycles between frames.
- Isolated frame: after the last bit, ser_valid = 0 in the next cycle, and in_ready stays 1 in IDLE.
- Simultaneous events: rst overrides everything, including an accept on the same edge.

## Test plan
- Reset and idle:
  - Stimulus: assert rst mid-simulation with in_valid = 1.
  - Response: every output is 0, including in_ready. One cycle after rst releases, in_ready = 1 and ser_valid = 0.
- Single frame, W=8, BIT_CYCLES=1:
  - Stimulus: accept 8'hA5 at edge N.
  - Response: ser_out reads 1,0,1,0,0,1,0,1 over cycles N+1..N+8. ser_first is high only in N+1, ser_last only in N+8, and ser_valid = 0 in N+9.
- Bit stretch, W=8, BIT_CYCLES=3:
  - Stimulus: send 8'h81.
  - Response: ser_out = 1 for 3 cycles, 0 for 18 cycles, then 1 for 3 cycles. ser_valid spans exactly 24 cycles.
- Back-to-back:
  - Stimulus: hold in_valid = 1 and present 8'hFF then 8'h00.
  - Response: 16 consecutive ser_valid cycles reading eight 1s then eight 0s. in_ready pulses only in the final bit cycle of each frame, and ser_first rises in the cycle right after ser_last.
- Backpressure:
  - Stimulus: raise in_valid with 8'h3C mid-frame and change in_data every cycle until it is accepted.
  - Response: the current frame is unaffected. The word sent next is the value present in the final bit cycle.
- Reset mid-frame:
  - Stimulus: assert rst after 4 bits of 8'hF0.
  - Response: ser_valid drops at once with no further bits. After release, a new word of 8'h0F serializes correctly from ser_first.
